multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter OP_W, default 5: opcode field width; opcode decode SHALL use the low 5 bits, and any nonzero upper bits SHALL make the opcode illegal.
REQ-002 Parameter ALUOP_W, default 5: ALU op field width.
REQ-003 Parameter MD_MAX, default 64: maximum number of multdiv wait cycles before timeout.
REQ-004 Parameter MD_EN, default 1: when 0, mul/div SHALL decode as illegal.
REQ-005 clock  in  1  single clock; all state SHALL update on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 opcode  in  OP_W  instruction opcode from the instruction register (IR).
REQ-008 aluop  in  ALUOP_W  R-type ALU op field from the IR.
REQ-009 alu_ne, alu_lt  in  1 each  ALU compare flags, valid during EXEC.
REQ-010 alu_ovf  in  1  ALU overflow flag, valid during EXEC.
REQ-011 md_rdy, md_exc  in  1 each  multdiv result-ready and exception flags.
REQ-012 rstatus_nz  in  1  high when r30 is nonzero.
REQ-013 ir_we, pc_we, dmem_we, rf_we  out  1 each  write enables.
REQ-014 alu_op_ctrl  out  ALUOP_W  equals aluop for R-type, else 0.
REQ-015 alu_inb_ctrl  out  1  selects the immediate as ALU input B.
REQ-016 rtar_ctrl  out  1  selects rd as the second read register.
REQ-017 pc_sel  out  2  PC source: 0 = pc+1, 1 = pc+1+imm, 2 = target, 3 = rd.
REQ-018 wd_sel  out  2  write-data source: 0 = ALU, 1 = memory, 2 = pc, 3 = exception code or target.
REQ-019 wr_rstatus  out  1  forces the write destination to r30.
REQ-020 exc_code  out  3  exception code: 1 add, 2 addi, 3 sub, 4 mul, 5 div.
REQ-021 md_start  out  1  one-cycle multdiv start pulse.
REQ-022 illegal, md_timeout  out  1 each  one-cycle fault pulses.
REQ-023 state  out  3  current state encoding.

Function
REQ-024 States and encodings SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, MDWAIT=5.
REQ-025 Any unlisted output SHALL be 0 in every state.
REQ-026 FETCH: ir_we=1, pc_we=1, pc_sel=0; next state DECODE.
REQ-027 DECODE: the rtar_ctrl decode SHALL be valid (1 for sw/bne/blt/jr, else 0); next state EXEC, or FETCH with illegal=1 for any opcode outside {0,1,2,3,4,5,6,7,8,21,22}.
REQ-028 EXEC, j: pc_we=1, pc_sel=2; next FETCH.
REQ-029 EXEC, jal: pc_we=1, pc_sel=2, rf_we=1, wd_sel=2, destination r31; next FETCH.
REQ-030 EXEC, jr: pc_we=1, pc_sel=3; next FETCH.
REQ-031 EXEC, bne: pc_we=alu_ne, pc_sel=1; blt: pc_we=alu_lt, pc_sel=1; next FETCH.
REQ-032 EXEC, bex: pc_we=rstatus_nz, pc_sel=2; next FETCH.
REQ-033 EXEC, setx: rf_we=1, wr_rstatus=1, wd_sel=3; next FETCH.
REQ-034 EXEC, lw/sw: alu_inb_ctrl=1; next MEM.
REQ-035 EXEC, addi or R non-muldiv: next WB; the alu_ovf value for add/sub/addi SHALL be registered for use in WB.
REQ-036 EXEC, R mul (aluop=6) or div (aluop=7): md_start=1 for exactly one cycle; next MDWAIT.
REQ-037 MEM: sw SHALL assert dmem_we=1 and go to FETCH; lw SHALL go to WB.
REQ-038 WB: rf_we=1; wd_sel=1 for lw, else 0.
REQ-039 WB with registered overflow or md_exc set: the register write SHALL be redirected with wr_rstatus=1, wd_sel=3, and the matching exc_code.
REQ-040 WB: next state FETCH.
REQ-041 MDWAIT: a saturating counter SHALL increment each cycle.
REQ-042 MDWAIT, md_rdy=1: next WB.
REQ-043 MDWAIT, counter reaching MD_MAX without md_rdy: md_timeout=1, no register write, next FETCH.
REQ-044 MDWAIT, md_rdy and timeout in the same cycle: md_rdy SHALL win.
REQ-045 Instruction latency SHALL be: j/jal/jr/branch/bex/setx 3 cycles; sw, R-type, addi 4; lw 5; mul/div 4 + wait cycles.
REQ-046 md_start SHALL never assert outside the EXEC-to-MDWAIT transition.

Reset
REQ-047 reset=1 SHALL force state=FETCH, clear the counter and the overflow register, and drive all outputs to 0 in the same cycle, overriding any FSM action.
REQ-048 Reset asserted mid-instruction, including during MDWAIT, SHALL abort the instruction with no pending write; FETCH SHALL begin on the first cycle after reset deasserts.

Verification
REQ-049 Reset, then lw (opcode 8) -> state sequence 0,1,2,3,4,0; dmem_we never 1; rf_we=1 with wd_sel=1 only in WB.
REQ-050 bne with alu_ne=0, then alu_ne=1 -> pc_we=0, then pc_we=1 with pc_sel=1 in EXEC; 3 cycles each.
REQ-051 add (aluop 0) with alu_ovf=1 -> WB shows rf_we=1, wr_rstatus=1, exc_code=1.
REQ-052 mul with md_rdy after 10 cycles -> single md_start pulse, 10 MDWAIT cycles, then WB.
REQ-053 div with md_rdy never asserted, MD_MAX=8 -> md_timeout pulse after 8 MDWAIT cycles, rf_we stays 0, then FETCH.
REQ-054 Opcode 31, and reset pulsed during MDWAIT -> illegal pulse in DECODE; reset returns state to 0 with all outputs 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM: FETCH/DECODE/EXEC/MEM/WB plus a bounded
// wait state for the external multiply/divide unit, with exception redirection.
module multicycle_ctrl #(
  parameter int OP_W    = 5,
  parameter int ALUOP_W = 5,
  parameter int MD_MAX  = 64,
  parameter int MD_EN   = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [OP_W-1:0]    opcode,
  input  logic [ALUOP_W-1:0] aluop,
  input  logic               alu_ne,
  input  logic               alu_lt,
  input  logic               alu_ovf,
  input  logic               md_rdy,
  input  logic               md_exc,
  input  logic               rstatus_nz,
  output logic               ir_we,
  output logic               pc_we,
  output logic               dmem_we,
  output logic               rf_we,
  output logic [ALUOP_W-1:0] alu_op_ctrl,
  output logic               alu_inb_ctrl,
  output logic               rtar_ctrl,
  output logic [1:0]         pc_sel,
  output logic [1:0]         wd_sel,
  output logic               wr_rstatus,
  output logic [2:0]         exc_code,
  output logic               md_start,
  output logic               illegal,
  output logic               md_timeout,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_MDWAIT = 3'd5
  } state_t;

  localparam logic [4:0] OP_R    = 5'd0;
  localparam logic [4:0] OP_J    = 5'd1;
  localparam logic [4:0] OP_BNE  = 5'd2;
  localparam logic [4:0] OP_JAL  = 5'd3;
  localparam logic [4:0] OP_JR   = 5'd4;
  localparam logic [4:0] OP_ADDI = 5'd5;
  localparam logic [4:0] OP_BLT  = 5'd6;
  localparam logic [4:0] OP_SW   = 5'd7;
  localparam logic [4:0] OP_LW   = 5'd8;
  localparam logic [4:0] OP_SETX = 5'd21;
  localparam logic [4:0] OP_BEX  = 5'd22;

  localparam logic [1:0] PC_INC = 2'd0;
  localparam logic [1:0] PC_REL = 2'd1;
  localparam logic [1:0] PC_TGT = 2'd2;
  localparam logic [1:0] PC_RD  = 2'd3;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC  = 2'd2;
  localparam logic [1:0] WD_EXC = 2'd3;

  localparam int CNT_W = $clog2(MD_MAX + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [4:0] op5;
  logic       op_hi_nz;
  logic       op_ok;
  logic       is_r, is_muldiv, is_addi, is_lw, is_sw, ovf_op, uses_rd, legal;
  logic [2:0] exc_sel;

  assign op5 = opcode[4:0];

  // Any set bit above the 5-bit opcode field makes the instruction illegal.
  if (OP_W > 5) begin : g_op_hi
    assign op_hi_nz = |opcode[OP_W-1:5];
  end else begin : g_op_no_hi
    assign op_hi_nz = 1'b0;
  end

  assign op_ok     = !op_hi_nz;
  assign is_r      = op_ok && (op5 == OP_R);
  assign is_muldiv = is_r && (aluop == ALUOP_W'(6) || aluop == ALUOP_W'(7));
  assign is_addi   = op_ok && (op5 == OP_ADDI);
  assign is_lw     = op_ok && (op5 == OP_LW);
  assign is_sw     = op_ok && (op5 == OP_SW);
  assign ovf_op    = is_addi || (is_r && (aluop == ALUOP_W'(0) || aluop == ALUOP_W'(1)));
  assign uses_rd   = op_ok && (op5 inside {OP_SW, OP_BNE, OP_BLT, OP_JR});
  assign legal     = op_ok
                     && (op5 inside {OP_R, OP_J, OP_BNE, OP_JAL, OP_JR, OP_ADDI,
                                     OP_BLT, OP_SW, OP_LW, OP_SETX, OP_BEX})
                     && !(is_muldiv && MD_EN == 0);

  always_comb begin
    exc_sel = 3'd0;
    if (is_addi) begin
      exc_sel = 3'd2;
    end else if (is_r) begin
      case (aluop)
        ALUOP_W'(0): exc_sel = 3'd1;
        ALUOP_W'(1): exc_sel = 3'd3;
        ALUOP_W'(6): exc_sel = 3'd4;
        ALUOP_W'(7): exc_sel = 3'd5;
        default:     exc_sel = 3'd0;
      endcase
    end
  end

  // NOTE: every output and next-state signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    dmem_we      = 1'b0;
    rf_we        = 1'b0;
    alu_op_ctrl  = '0;
    alu_inb_ctrl = 1'b0;
    rtar_ctrl    = 1'b0;
    pc_sel       = PC_INC;
    wd_sel       = WD_ALU;
    wr_rstatus   = 1'b0;
    exc_code     = 3'd0;
    md_start     = 1'b0;
    illegal      = 1'b0;
    md_timeout   = 1'b0;
    state        = 3'd0;

    // Reset leaves every output at its zero default, regardless of state.
    if (!reset) begin
      state       = state_q;
      alu_op_ctrl = is_r ? aluop : '0;
      case (state_q)
        S_FETCH: begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          pc_sel  = PC_INC;
          state_d = S_DECODE;
        end
        S_DECODE: begin
          rtar_ctrl = uses_rd;
          if (legal) begin
            state_d = S_EXEC;
          end else begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        end
        S_EXEC: begin
          state_d = S_FETCH;
          ovf_d   = ovf_op && alu_ovf;
          cnt_d   = '0;
          if (is_muldiv) begin
            md_start = 1'b1;
            state_d  = S_MDWAIT;
          end else if (is_r || is_addi) begin
            state_d = S_WB;
          end else if (is_lw || is_sw) begin
            alu_inb_ctrl = 1'b1;
            state_d      = S_MEM;
          end else if (op_ok) begin
            case (op5)
              OP_J:   begin pc_we = 1'b1;       pc_sel = PC_TGT; end
              OP_JAL: begin pc_we = 1'b1;       pc_sel = PC_TGT; rf_we = 1'b1; wd_sel = WD_PC; end
              OP_JR:  begin pc_we = 1'b1;       pc_sel = PC_RD;  end
              OP_BNE: begin pc_we = alu_ne;     pc_sel = PC_REL; end
              OP_BLT: begin pc_we = alu_lt;     pc_sel = PC_REL; end
              OP_BEX: begin pc_we = rstatus_nz; pc_sel = PC_TGT; end
              OP_SETX: begin
                rf_we      = 1'b1;
                wr_rstatus = 1'b1;
                wd_sel     = WD_EXC;
              end
              default: ;
            endcase
          end
        end
        S_MEM: begin
          if (is_sw) begin
            dmem_we = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
        S_WB: begin
          rf_we   = 1'b1;
          wd_sel  = is_lw ? WD_MEM : WD_ALU;
          state_d = S_FETCH;
          if (ovf_q || (is_muldiv && md_exc)) begin
            wr_rstatus = 1'b1;
            wd_sel     = WD_EXC;
            exc_code   = exc_sel;
          end
        end
        S_MDWAIT: begin
          cnt_d = (cnt_q == CNT_W'(MD_MAX)) ? cnt_q : cnt_q + 1'b1;
          // A ready result in the final allowed cycle still completes normally.
          if (md_rdy) begin
            state_d = S_WB;
          end else if (cnt_q == CNT_W'(MD_MAX - 1)) begin
            md_timeout = 1'b1;
            state_d    = S_FETCH;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: an instruction-level model expands each
// instruction into its expected per-cycle control outputs; two DUT instances.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [2:0] st;
    logic       ir_we, pc_we, dmem_we, rf_we, alu_inb, rtar;
    logic [1:0] pc_sel, wd_sel;
    logic       wr_rs;
    logic [2:0] exc;
    logic       md_start, illegal, md_to;
    logic [4:0] alu_op;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rst_a, rst_b, sel_b;
  logic [5:0] opcode;
  logic [4:0] aluop;
  logic       alu_ne, alu_lt, alu_ovf, md_rdy, md_exc, rstatus_nz;

  logic       ir_we_a, pc_we_a, dmem_we_a, rf_we_a, alu_inb_a, rtar_a, wr_rs_a;
  logic       md_start_a, illegal_a, md_to_a;
  logic [4:0] alu_op_a;
  logic [1:0] pc_sel_a, wd_sel_a;
  logic [2:0] exc_a, state_a;
  logic       ir_we_b, pc_we_b, dmem_we_b, rf_we_b, alu_inb_b, rtar_b, wr_rs_b;
  logic       md_start_b, illegal_b, md_to_b;
  logic [4:0] alu_op_b;
  logic [1:0] pc_sel_b, wd_sel_b;
  logic [2:0] exc_b, state_b;

  logic [24:0] obs_a, obs_b, obs;

  // Default instance: 5-bit opcode, 64-cycle multdiv limit.
  multicycle_ctrl dut_a (
    .clock(clock), .reset(rst_a), .opcode(opcode[4:0]), .aluop(aluop),
    .alu_ne(alu_ne), .alu_lt(alu_lt), .alu_ovf(alu_ovf), .md_rdy(md_rdy),
    .md_exc(md_exc), .rstatus_nz(rstatus_nz),
    .ir_we(ir_we_a), .pc_we(pc_we_a), .dmem_we(dmem_we_a), .rf_we(rf_we_a),
    .alu_op_ctrl(alu_op_a), .alu_inb_ctrl(alu_inb_a), .rtar_ctrl(rtar_a),
    .pc_sel(pc_sel_a), .wd_sel(wd_sel_a), .wr_rstatus(wr_rs_a), .exc_code(exc_a),
    .md_start(md_start_a), .illegal(illegal_a), .md_timeout(md_to_a), .state(state_a)
  );

  // Wide-opcode instance with a short multdiv limit.
  multicycle_ctrl #(.OP_W(6), .MD_MAX(8)) dut_b (
    .clock(clock), .reset(rst_b), .opcode(opcode), .aluop(aluop),
    .alu_ne(alu_ne), .alu_lt(alu_lt), .alu_ovf(alu_ovf), .md_rdy(md_rdy),
    .md_exc(md_exc), .rstatus_nz(rstatus_nz),
    .ir_we(ir_we_b), .pc_we(pc_we_b), .dmem_we(dmem_we_b), .rf_we(rf_we_b),
    .alu_op_ctrl(alu_op_b), .alu_inb_ctrl(alu_inb_b), .rtar_ctrl(rtar_b),
    .pc_sel(pc_sel_b), .wd_sel(wd_sel_b), .wr_rstatus(wr_rs_b), .exc_code(exc_b),
    .md_start(md_start_b), .illegal(illegal_b), .md_timeout(md_to_b), .state(state_b)
  );

  assign obs_a = {state_a, ir_we_a, pc_we_a, dmem_we_a, rf_we_a, alu_inb_a, rtar_a,
                  pc_sel_a, wd_sel_a, wr_rs_a, exc_a, md_start_a, illegal_a, md_to_a, alu_op_a};
  assign obs_b = {state_b, ir_we_b, pc_we_b, dmem_we_b, rf_we_b, alu_inb_b, rtar_b,
                  pc_sel_b, wd_sel_b, wr_rs_b, exc_b, md_start_b, illegal_b, md_to_b, alu_op_b};
  assign obs   = sel_b ? obs_b : obs_a;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_instr  = 0;
  exp_t plan[$];
  bit   rdys[$];

  task automatic check(input string tag, input logic [24:0] got, input logic [24:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic [2:0] exc_of(input logic [5:0] op, input logic [4:0] aop);
    if (op == 6'd5) return 3'd2;
    case (aop)
      5'd0:    return 3'd1;
      5'd1:    return 3'd3;
      5'd6:    return 3'd4;
      5'd7:    return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  // Expand one instruction into its expected cycle-by-cycle control outputs.
  // rdy_at: MDWAIT cycle (1-based) in which md_rdy is raised; 0 means never.
  task automatic plan_instr(input logic [5:0] op, input logic [4:0] aop,
                            input bit ne, lt, ovf, mexc, rnz,
                            input int rdy_at, input int md_max);
    exp_t base, e;
    bit   r, md, legal, ovf_hit;
    plan.delete();
    rdys.delete();
    r     = (op == 6'd0);
    md    = r && (aop == 5'd6 || aop == 5'd7);
    legal = op inside {6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd21, 6'd22};
    base  = '0;
    base.alu_op = r ? aop : 5'd0;

    e = base; e.st = 3'd0; e.ir_we = 1'b1; e.pc_we = 1'b1;
    plan.push_back(e); rdys.push_back(1'($urandom_range(0, 1)));

    e = base; e.st = 3'd1;
    e.rtar    = op inside {6'd2, 6'd4, 6'd6, 6'd7};
    e.illegal = !legal;
    plan.push_back(e); rdys.push_back(1'($urandom_range(0, 1)));
    if (!legal) return;

    e = base; e.st = 3'd2;
    case (op)
      6'd1:  begin e.pc_we = 1'b1; e.pc_sel = 2'd2; end
      6'd3:  begin e.pc_we = 1'b1; e.pc_sel = 2'd2; e.rf_we = 1'b1; e.wd_sel = 2'd2; end
      6'd4:  begin e.pc_we = 1'b1; e.pc_sel = 2'd3; end
      6'd2:  begin e.pc_we = ne;   e.pc_sel = 2'd1; end
      6'd6:  begin e.pc_we = lt;   e.pc_sel = 2'd1; end
      6'd22: begin e.pc_we = rnz;  e.pc_sel = 2'd2; end
      6'd21: begin e.rf_we = 1'b1; e.wr_rs = 1'b1; e.wd_sel = 2'd3; end
      6'd7, 6'd8: e.alu_inb = 1'b1;
      default: e.md_start = md;
    endcase
    plan.push_back(e); rdys.push_back(1'($urandom_range(0, 1)));
    if (op inside {6'd1, 6'd2, 6'd3, 6'd4, 6'd6, 6'd21, 6'd22}) return;

    if (op == 6'd7 || op == 6'd8) begin
      e = base; e.st = 3'd3; e.dmem_we = (op == 6'd7);
      plan.push_back(e); rdys.push_back(1'($urandom_range(0, 1)));
      if (op == 6'd7) return;
    end

    if (md) begin
      for (int k = 1; k <= md_max; k++) begin
        e = base; e.st = 3'd5;
        if (k == rdy_at) begin
          plan.push_back(e); rdys.push_back(1'b1);
          break;
        end
        if (k == md_max) begin
          e.md_to = 1'b1;
          plan.push_back(e); rdys.push_back(1'b0);
          return;
        end
        plan.push_back(e); rdys.push_back(1'b0);
      end
    end

    e = base; e.st = 3'd4; e.rf_we = 1'b1;
    e.wd_sel = (op == 6'd8) ? 2'd1 : 2'd0;
    ovf_hit  = (ovf && (op == 6'd5 || (r && aop <= 5'd1))) || (md && mexc);
    if (ovf_hit) begin
      e.wr_rs  = 1'b1;
      e.wd_sel = 2'd3;
      e.exc    = exc_of(op, aop);
    end
    plan.push_back(e); rdys.push_back(1'($urandom_range(0, 1)));
  endtask

  // Drive one instruction on the active DUT; rst_at >= 0 pulses reset in that cycle.
  task automatic run_instr(input logic [5:0] op, input logic [4:0] aop,
                           input bit ne, lt, ovf, mexc, rnz,
                           input int rdy_at, input int rst_at);
    plan_instr(op, aop, ne, lt, ovf, mexc, rnz, rdy_at, sel_b ? 8 : 64);
    n_instr++;
    for (int i = 0; i < plan.size(); i++) begin
      @(posedge clock); #1;
      if (sel_b) rst_b = 1'b0; else rst_a = 1'b0;
      opcode = op; aluop = aop; alu_ne = ne; alu_lt = lt; alu_ovf = ovf;
      md_exc = mexc; rstatus_nz = rnz; md_rdy = rdys[i];
      if (i == rst_at) begin
        if (sel_b) rst_b = 1'b1; else rst_a = 1'b1;
        @(negedge clock);
        check($sformatf("i%0d op%0d rst@c%0d", n_instr, op, i), obs, '0);
        return;
      end
      @(negedge clock);
      check($sformatf("i%0d op%0d a%0d c%0d", n_instr, op, aop, i), obs, plan[i]);
    end
  endtask

  task automatic run_random(input int count, input bit wide);
    logic [5:0] legal_ops[11] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd21, 6'd22};
    logic [5:0] op;
    logic [4:0] aop;
    int         rdy_at, rst_at;
    for (int n = 0; n < count; n++) begin
      if ($urandom_range(0, 99) < 85) op = legal_ops[$urandom_range(0, 10)];
      else                            op = 6'($urandom_range(0, wide ? 63 : 31));
      if ($urandom_range(0, 3) == 0) aop = 5'($urandom_range(0, 31));
      else                           aop = 5'($urandom_range(0, 7));
      rdy_at = wide ? $urandom_range(1, 10) : $urandom_range(1, 12);
      if ($urandom_range(0, 19) == 0) rdy_at = 0;
      rst_at = ($urandom_range(0, 14) == 0) ? $urandom_range(0, 6) : -1;
      run_instr(op, aop, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), rdy_at, rst_at);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; sel_b = 1'b0;
    opcode = '0; aluop = '0; alu_ne = 1'b0; alu_lt = 1'b0; alu_ovf = 1'b0;
    md_rdy = 1'b0; md_exc = 1'b0; rstatus_nz = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_a", obs_a, '0);
    check("reset_b", obs_b, '0);

    // Directed instructions on the default instance.
    run_instr(6'd8,  5'd0, 0, 0, 0, 0, 0, 0, -1);  // lw
    run_instr(6'd2,  5'd0, 0, 0, 0, 0, 0, 0, -1);  // bne not taken
    run_instr(6'd2,  5'd0, 1, 0, 0, 0, 0, 0, -1);  // bne taken
    run_instr(6'd0,  5'd0, 0, 0, 1, 0, 0, 0, -1);  // add overflow
    run_instr(6'd0,  5'd6, 0, 0, 0, 0, 0, 10, -1); // mul ready after 10 waits
    run_instr(6'd31, 5'd0, 0, 0, 0, 0, 0, 0, -1);  // illegal opcode
    run_instr(6'd0,  5'd7, 0, 0, 0, 0, 0, 20, 5);  // reset during MDWAIT
    run_instr(6'd21, 5'd0, 0, 0, 0, 0, 0, 0, -1);  // setx
    run_instr(6'd22, 5'd0, 0, 0, 0, 0, 1, 0, -1);  // bex taken
    run_instr(6'd3,  5'd0, 0, 0, 0, 0, 0, 0, -1);  // jal
    run_instr(6'd4,  5'd0, 0, 0, 0, 0, 0, 0, -1);  // jr
    run_instr(6'd7,  5'd0, 0, 0, 0, 0, 0, 0, -1);  // sw
    run_instr(6'd5,  5'd0, 0, 0, 1, 0, 0, 0, -1);  // addi overflow
    run_instr(6'd0,  5'd1, 0, 0, 1, 0, 0, 0, -1);  // sub overflow
    run_instr(6'd0,  5'd7, 0, 0, 1, 1, 0, 3, -1);  // div with md_exc
    run_instr(6'd6,  5'd0, 0, 1, 0, 0, 0, 0, -1);  // blt taken
    run_random(150, 1'b0);

    // Switch to the short-timeout, wide-opcode instance.
    @(posedge clock); #1;
    rst_a = 1'b1;
    sel_b = 1'b1;
    @(negedge clock);
    check("held_a", obs_a, '0);
    run_instr(6'd0,  5'd7, 0, 0, 0, 0, 0, 0, -1);  // div never ready: timeout
    run_instr(6'd0,  5'd6, 0, 0, 0, 1, 0, 8, -1);  // ready on the timeout cycle
    run_instr(6'd32, 5'd0, 0, 0, 0, 0, 0, 0, -1);  // upper opcode bit set
    run_instr(6'd40, 5'd0, 0, 0, 0, 0, 0, 0, -1);  // lw with upper bit set
    run_instr(6'd0,  5'd6, 0, 0, 0, 0, 0, 0, 6);   // reset during MDWAIT
    run_instr(6'd8,  5'd0, 0, 0, 0, 0, 0, 0, -1);
    run_random(100, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
